// File: rtl/mux_pipe_n_pkg.sv
// Shared definitions for the registered N-to-1 mux with skid buffer:
// occupancy state encoding and a constant-foldable clog2 helper.
package mux_pipe_n_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/mux_pipe_n_if.sv
// Valid/ready bus between a data source, the mux pipeline and its consumer.
interface mux_pipe_n_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
);
  logic [NUM_IN*WIDTH-1:0] d;
  logic [SEL_W-1:0]        select;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out;
  logic                    out_err;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output d, select, in_valid, out_ready,
    input  in_ready, out, out_err, out_valid
  );

  modport slave (
    input  d, select, in_valid, out_ready,
    output in_ready, out, out_err, out_valid
  );
endinterface

// File: rtl/mux_sel_n.sv
// Combinational N-to-1 selector; unused select codes map to DEFAULT_VAL
// with err raised.
module mux_sel_n #(
  parameter int               WIDTH       = 32,
  parameter int               NUM_IN      = 4,
  parameter int               SEL_W       = 2,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input  logic [NUM_IN*WIDTH-1:0] d,
  input  logic [SEL_W-1:0]        select,
  output logic [WIDTH-1:0]        value,
  output logic                    err
);

  localparam int              SLOTS    = 1 << SEL_W;
  localparam logic [SEL_W:0]  NUM_IN_W = (SEL_W + 1)'(NUM_IN);

  // Every select code owns a slot, so the array index never runs off the end.
  logic [WIDTH-1:0] slot [SLOTS];

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    if (gi < NUM_IN) begin : g_in
      assign slot[gi] = d[gi*WIDTH +: WIDTH];
    end else begin : g_def
      assign slot[gi] = DEFAULT_VAL;
    end
  end

  assign value = slot[select];
  assign err   = ({1'b0, select} >= NUM_IN_W);

endmodule

// File: rtl/mux_pipe_n.sv
// Registered N-to-1 mux with valid/ready on both sides; a main + skid register
// pair keeps full throughput while in_ready stays a pure flop output.
module mux_pipe_n
  import mux_pipe_n_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               NUM_IN      = 4,
  parameter int               SEL_W       = clog2(NUM_IN),
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input logic          clk,
  input logic          rst,
  mux_pipe_n_if.slave  bus
);

  if (NUM_IN < 2 || NUM_IN > 16 || (1 << SEL_W) < NUM_IN) begin : g_bad_params
    $error("mux_pipe_n: NUM_IN must be 2..16 and fit in SEL_W bits");
  end

  logic [WIDTH-1:0] sel_value;
  logic             sel_err;

  mux_sel_n #(
    .WIDTH       (WIDTH),
    .NUM_IN      (NUM_IN),
    .SEL_W       (SEL_W),
    .DEFAULT_VAL (DEFAULT_VAL)
  ) u_sel (
    .d      (bus.d),
    .select (bus.select),
    .value  (sel_value),
    .err    (sel_err)
  );

  state_t           state_reg;
  logic [WIDTH-1:0] main_data_reg;
  logic             main_err_reg;
  logic [WIDTH-1:0] skid_data_reg;
  logic             skid_err_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             accept;
  logic             emit;

  assign accept = bus.in_valid && in_ready_reg;
  assign emit   = out_valid_reg && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_EMPTY;
      main_data_reg <= '0;
      main_err_reg  <= 1'b0;
      skid_data_reg <= '0;
      skid_err_reg  <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            main_data_reg <= sel_value;
            main_err_reg  <= sel_err;
            out_valid_reg <= 1'b1;
            state_reg     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && !emit) begin
            // Consumer stalled: park the new entry, main keeps the head.
            skid_data_reg <= sel_value;
            skid_err_reg  <= sel_err;
            in_ready_reg  <= 1'b0;
            state_reg     <= ST_TWO;
          end else if (accept) begin
            main_data_reg <= sel_value;
            main_err_reg  <= sel_err;
          end else if (emit) begin
            out_valid_reg <= 1'b0;
            state_reg     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (emit) begin
            main_data_reg <= skid_data_reg;
            main_err_reg  <= skid_err_reg;
            in_ready_reg  <= 1'b1;
            state_reg     <= ST_ONE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= ST_EMPTY;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out       = main_data_reg;
  assign bus.out_err   = main_err_reg;
  assign bus.out_valid = out_valid_reg;

endmodule

// File: tb/tb_mux_pipe_n.sv
// Bench for mux_pipe_n: directed vector table, async-reset sequence and a
// randomised valid/ready run checked against a queue model.
module tb_mux_pipe_n;

  logic clk;
  logic rst;

  mux_pipe_n_if #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) bus_a ();
  mux_pipe_n_if #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) bus_e ();
  mux_pipe_n_if #(.WIDTH(16), .NUM_IN(8), .SEL_W(3)) bus_r ();

  mux_pipe_n #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .DEFAULT_VAL(32'h0)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  mux_pipe_n #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .DEFAULT_VAL(32'hDEADBEEF)) dut_e (
    .clk(clk), .rst(rst), .bus(bus_e)
  );
  mux_pipe_n #(.WIDTH(16), .NUM_IN(8), .SEL_W(3), .DEFAULT_VAL(16'h0)) dut_r (
    .clk(clk), .rst(rst), .bus(bus_r)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp;
  int n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          unit;     // 0 = 4-input DUT, 1 = 3-input DUT
    logic [1:0]  sel;
    bit          iv;
    bit          ordy;
    bit          exp_ov;
    bit          exp_ir;
    logic [31:0] exp_out;
    bit          exp_err;
    string       name;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  logic [15:0] exp_q [$];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    logic        ov, ir, er;
    logic [31:0] ov_out;
    logic [127:0] rd;
    logic [2:0]  rsel;
    logic        riv, rord, acc, emt;

    n_cmp  = 0;
    n_fail = 0;

    // Streaming, backpressure with an ignored request while full, then the
    // out-of-range unit.
    vecs[0]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hAAAA0000, 1'b0, "stream0"};
    vecs[1]  = '{1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hBBBB0001, 1'b0, "stream1"};
    vecs[2]  = '{1'b0, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 32'hCCCC0002, 1'b0, "stream2"};
    vecs[3]  = '{1'b0, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDDDD0003, 1'b0, "stream3"};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        1'b0, "stream_drain"};
    vecs[5]  = '{1'b0, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hBBBB0001, 1'b0, "bp_first"};
    vecs[6]  = '{1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 32'hBBBB0001, 1'b0, "bp_full"};
    vecs[7]  = '{1'b0, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 32'hBBBB0001, 1'b0, "bp_ignored"};
    vecs[8]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hCCCC0002, 1'b0, "bp_emit1"};
    vecs[9]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        1'b0, "bp_emit2"};
    vecs[10] = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, "err_sel3"};
    vecs[11] = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hAAAA0000, 1'b0, "err_sel0"};
    vecs[12] = '{1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 32'hCCCC0002, 1'b0, "err_sel_last"};
    vecs[13] = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        1'b0, "err_drain"};

    bus_a.d = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    bus_e.d = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    bus_r.d = '0;
    bus_a.select = '0; bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
    bus_e.select = '0; bus_e.in_valid = 1'b0; bus_e.out_ready = 1'b1;
    bus_r.select = '0; bus_r.in_valid = 1'b0; bus_r.out_ready = 1'b1;

    // Reset and idle
    rst = 1'b1;
    #22;
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk($sformatf("idle%0d_out_valid", c), 32'(bus_a.out_valid), 32'd0);
      chk($sformatf("idle%0d_in_ready", c), 32'(bus_a.in_ready), 32'd1);
      chk($sformatf("idle%0d_out", c), bus_a.out, 32'h0);
    end

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].unit == 1'b0) begin
        bus_a.select = vecs[i].sel; bus_a.in_valid = vecs[i].iv; bus_a.out_ready = vecs[i].ordy;
        bus_e.in_valid = 1'b0; bus_e.out_ready = 1'b1;
      end else begin
        bus_e.select = vecs[i].sel; bus_e.in_valid = vecs[i].iv; bus_e.out_ready = vecs[i].ordy;
        bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
      end
      @(posedge clk); #1;
      if (vecs[i].unit == 1'b0) begin
        ov = bus_a.out_valid; ir = bus_a.in_ready; ov_out = bus_a.out; er = bus_a.out_err;
      end else begin
        ov = bus_e.out_valid; ir = bus_e.in_ready; ov_out = bus_e.out; er = bus_e.out_err;
      end
      $display("vec %0d %s: out_valid=%0b in_ready=%0b out=0x%0h err=%0b",
               i, vecs[i].name, ov, ir, ov_out, er);
      chk({vecs[i].name, "/out_valid"}, 32'(ov), 32'(vecs[i].exp_ov));
      chk({vecs[i].name, "/in_ready"}, 32'(ir), 32'(vecs[i].exp_ir));
      if (vecs[i].exp_ov) begin
        chk({vecs[i].name, "/out"}, ov_out, vecs[i].exp_out);
        chk({vecs[i].name, "/out_err"}, 32'(er), 32'(vecs[i].exp_err));
      end
    end
    bus_e.in_valid = 1'b0;

    // Async reset while full
    bus_a.out_ready = 1'b0; bus_a.in_valid = 1'b1; bus_a.select = 2'd0;
    @(posedge clk); #1;
    bus_a.select = 2'd1;
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    chk("arst_pre_in_ready", 32'(bus_a.in_ready), 32'd0);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus_a.out_valid), 32'd0);
    chk("arst_in_ready", 32'(bus_a.in_ready), 32'd1);
    chk("arst_out", bus_a.out, 32'h0);
    $display("arst: out_valid=%0b in_ready=%0b out=0x%0h", bus_a.out_valid, bus_a.in_ready, bus_a.out);
    #1;
    rst = 1'b0;
    bus_a.select = 2'd2; bus_a.in_valid = 1'b1; bus_a.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    chk("arst_next_valid", 32'(bus_a.out_valid), 32'd1);
    chk("arst_next_out", bus_a.out, 32'hCCCC0002);
    @(posedge clk); #1;
    chk("arst_alone", 32'(bus_a.out_valid), 32'd0);
    $display("arst_after: out_valid=%0b in_ready=%0b", bus_a.out_valid, bus_a.in_ready);

    // Randomised valid/ready with queue model
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < 4; k++) rd[k*32 +: 32] = $urandom;
      rsel = 3'($urandom_range(0, 7));
      riv  = ($urandom_range(0, 99) < 60);
      rord = ($urandom_range(0, 99) < 55);
      bus_r.d = rd; bus_r.select = rsel; bus_r.in_valid = riv; bus_r.out_ready = rord;
      acc = riv && bus_r.in_ready;
      emt = bus_r.out_valid && rord;
      if (emt && exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(rd[rsel*16 +: 16]);
      @(posedge clk); #1;
      chk("rnd_out_valid", 32'(bus_r.out_valid), 32'(exp_q.size() > 0));
      chk("rnd_in_ready", 32'(bus_r.in_ready), 32'(exp_q.size() < 2));
      if (exp_q.size() > 0) begin
        chk("rnd_out", 32'(bus_r.out), 32'(exp_q[0]));
        chk("rnd_out_err", 32'(bus_r.out_err), 32'd0);
      end
    end
    bus_r.in_valid = 1'b0; bus_r.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (bus_r.out_valid && exp_q.size() > 0) void'(exp_q.pop_front());
      @(posedge clk); #1;
    end
    chk("rnd_drain_model_empty", 32'(exp_q.size()), 32'd0);
    chk("rnd_drain_out_valid", 32'(bus_r.out_valid), 32'd0);
    $display("random: done, %0d compared so far", n_cmp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_pipe_n.md
Name: mux_pipe_n

Overview:
- Parametrised, registered N-to-1 multiplexer with a valid/ready handshake on both sides; successor to the fixed 4:1 32-bit combinational selector.
- Sits between multi-cycle datapath sources (PC, ALU result, memory data, immediates) and consuming registers or stages that can stall.
- A 2-entry skid buffer gives full throughput with a registered in_ready.
- An out-of-range select produces a defined default value plus an error flag instead of an undefined result.

Parameters:
- WIDTH, 32, bit width of each data input and of the output.
- NUM_IN, 4, number of data inputs; legal range 2..16.
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN (elaboration check).
- DEFAULT_VAL, 0, WIDTH-bit value output for an out-of-range select.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- d  input  NUM_IN*WIDTH  flat data bus; input i occupies bits [i*WIDTH +: WIDTH].
- select  input  SEL_W  input index, sampled with in_valid.
- in_valid  input  1  upstream offers d/select this cycle.
- in_ready  output  1  block accepts this cycle; registered.
- out  output  WIDTH  selected data, registered.
- out_err  output  1  set when the entry was captured with select >= NUM_IN.
- out_valid  output  1  out/out_err are valid.
- out_ready  input  1  downstream accepts this cycle.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values: out = 0, out_err = 0, out_valid = 0, in_ready = 1, skid register = 0, state = EMPTY.
- Accept: a transfer occurs on a clk edge where in_valid && in_ready.
- Capture rule: captured value = d[select*WIDTH +: WIDTH] if select < NUM_IN; otherwise DEFAULT_VAL with err = 1.
- Emit: a transfer occurs on an edge where out_valid && out_ready.
- Latency: 1 cycle. Data accepted at edge k is on out from edge k, i.e. visible in cycle k+1 when the buffer was EMPTY or draining.
- States: EMPTY (main invalid), ONE (main valid, skid empty), TWO (main and skid valid).
- EMPTY -> ONE on accept.
- ONE -> ONE on accept and emit together; main loads the new entry.
- ONE -> EMPTY on emit only.
- ONE -> TWO on accept without emit; the new entry goes to the skid register and main holds.
- TWO -> ONE on emit; skid moves to main. No accept is possible because in_ready = 0.
- TWO holds while out_ready = 0.
- Outputs: in_ready = (state != TWO), registered. out_valid = (state != EMPTY).
- out/out_err must remain stable while out_valid && !out_ready.
- Ordering: strict FIFO order; no entry is dropped or duplicated.
- No combinational path from in_valid, d or select to any output. No combinational path from out_ready to in_ready.
- in_valid while in_ready = 0 is ignored. Upstream must hold the request, but the block does not rely on that.
- An X or changing select while in_valid = 0 has no effect.
- Reset mid-operation: all entries are discarded immediately (asynchronous). The first accept after rst deasserts behaves as from EMPTY.
- Select equal to NUM_IN-1 is legal. Select of NUM_IN and above is an error; with NUM_IN = 2**SEL_W this error case is unreachable.

Decomposition:
- Shared package holds:
  - state encoding localparams ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2;
  - a clog2 function used to default and check SEL_W.
- One natural sub-module: mux_sel_n, the combinational parametrised selector (d, select -> value, err), instantiated once ahead of the skid buffer. The handshake/skid logic stays in mux_pipe_n.

Test Plan:
1. Reset and idle: rst = 1 then released, in_valid = 0 -> out_valid = 0, in_ready = 1, out = 0 for 10 cycles.
2. Streaming (WIDTH = 32, NUM_IN = 4): d = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000}, select 0..3 on consecutive cycles, in_valid = 1, out_ready = 1 -> out = AAAA0000, BBBB0001, CCCC0002, DDDD0003 one cycle after each accept, out_err = 0, in_ready stays 1.
3. Backpressure: out_ready = 0 while sending select = 1 then 2 ->
   - state reaches TWO; in_ready drops to 0 after the second accept;
   - out holds BBBB0001;
   - out_ready = 1 -> BBBB0001, then CCCC0002; in_ready returns to 1 one cycle after the first emit.
4. Out-of-range select: NUM_IN = 3, SEL_W = 2, DEFAULT_VAL = 32'hDEADBEEF, select = 3 -> out = DEADBEEF, out_err = 1. The next entry with select = 0 gives out_err = 0.
5. Async reset mid-operation: in state TWO, pulse rst between clock edges -> out_valid = 0 and in_ready = 1 immediately, without waiting for a clock edge. The next accepted item emerges alone.
6. Randomised valid/ready with a scoreboard on NUM_IN = 8, WIDTH = 16 for 10k cycles -> output sequence equals the accepted sequence, no loss or duplication, stability held under stall.
